xoodoo_perm_ctrl_sca: RTL and testbench
=======================================

XOODOO_PERM_CTRL_SCA -- requirements
Module: xoodoo_perm_ctrl_sca

Interface
REQ-001 SHALL have parameter NR_DEFAULT, default 12: the round count used when nrounds==0.
REQ-002 SHALL have port clk  in  1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1: asynchronous, active-low reset.
REQ-004 SHALL have ports in_valid in 1, in_ready out 1: masked-state input handshake.
REQ-005 SHALL have port nrounds  in  4: round count, 1..12; 0 selects NR_DEFAULT; values 13..15 are clamped to 12.
REQ-006 SHALL have ports din_0, din_1  in  384: the two input state shares.
REQ-007 SHALL have ports rnd_valid in 1, rnd_ready out 1, rnd_0 in 384, rnd_1 in 384: fresh-randomness stream.
REQ-008 SHALL have port dp_rst  out  1: synchronous active-high clear to the round datapath.
REQ-009 SHALL have ports dp_in_0, dp_in_1  out  384: round-datapath state shares.
REQ-010 SHALL have ports dp_rs0, dp_rs1  out  384: round-datapath randomness.
REQ-011 SHALL have port dp_rconst  out  32: round-datapath round constant.
REQ-012 SHALL have ports dp_out_0, dp_out_1  in  384: round-datapath output shares.
REQ-013 SHALL have ports dout_0, dout_1 out 384, dout_valid out 1, dout_ready in 1: result handshake.

Function
REQ-014 SHALL implement FSM states IDLE, PH_A, PH_B, FIN, DONE.
- PH_A: datapath captures its first register stage.
- PH_B: datapath captures its nonlinear output stage.
REQ-015 SHALL assert in_ready only in IDLE; on in_valid&&in_ready: load din_0/din_1 into share registers st_0/st_1, latch the round count, clear round counter cnt, go to PH_A.
REQ-016 SHALL, in PH_A, go to PH_B if rnd_valid; otherwise stay in PH_A (stall, unbounded).
REQ-017 SHALL, in PH_B, assert rnd_ready (one word consumed per round); go to PH_A with cnt+1 if cnt+1<nr, else go to FIN.
REQ-018 SHALL go FIN->DONE unconditionally; DONE->IDLE on dout_ready.
REQ-019 SHALL drive dp_in = dp_out only in the first cycle after PH_B (the fresh flag); otherwise drive dp_in = st.
REQ-020 SHALL load st <= dp_out at every edge ending a cycle with the fresh flag set (including FIN).
REQ-021 SHALL drive dp_rs0/dp_rs1 = rnd_0/rnd_1 combinationally; PRNG data held stable while rnd_valid && !rnd_ready, so each round sees the same word in PH_A and PH_B.
REQ-022 SHALL drive dp_rconst = RC[12-nr+cnt], stable throughout PH_A.
- RC[0..11] = 0x058,0x038,0x3C0,0x0D0,0x120,0x014,0x060,0x02C,0x380,0x0F0,0x1A0,0x012.
- Upper bits zero.
REQ-023 SHALL assert dp_rst in IDLE and DONE, deasserted otherwise.
REQ-024 SHALL drive dout = st and dout_valid=1 only in DONE; dout held while dout_ready is low.
REQ-025 SHALL clear st_0/st_1 to zero on DONE->IDLE; no share material is retained between jobs.
REQ-026 SHALL give latency, with rnd_valid constantly high: accept at edge T -> dout_valid high from edge T+2*nr+1 (25 cycles for nr=12); each stall cycle adds 1.
REQ-027 SHALL ignore in_valid outside IDLE; dout_ready is ignored outside DONE.
REQ-028 SHALL never combine shares: no signal depends on st_0^st_1 or dp_out_0^dp_out_1.

Reset
REQ-029 SHALL, on rst low, asynchronously set:
- state=IDLE, cnt=0, fresh flag=0, st_0=st_1=0, latched nr=12;
- outputs: in_ready=1, rnd_ready=0, dout_valid=0, dp_rst=1, dp_rconst=0, dp_in=0.
REQ-030 SHALL abort any job on reset mid-operation; no partial result is ever presented on dout.

Structure
REQ-031 SHALL take state width 384, lane width 32, round-constant table, FSM state encoding and max round count 12 from shared package xoodyak_sca_pkg.
REQ-032 SHALL place round-constant lookup in sub-module xoodoo_rc_rom (4-bit index in, 32-bit constant out, combinational).
REQ-033 SHALL be instantiated alongside, not containing, the round datapath; the wrapper connects dp_* ports.

Verification
REQ-034 Zero state, shares din_0=din_1=random R, nrounds=12, rnd always valid -> dout_0^dout_1 equals Xoodoo[12](0) golden model; dout_valid 25 cycles after accept.
REQ-035 Same stimulus, rnd_valid low for 3 cycles at round 5 PH_A -> identical unmasked result; dout_valid at cycle 28; rnd_ready pulses exactly 12 times.
REQ-036 nrounds=6 -> dp_rconst sequence 0x060,0x02C,0x380,0x0F0,0x1A0,0x012; result matches 6-round model; latency 13.
REQ-037 rst low during round 7 PH_B -> next cycle: in_ready=1, dout_valid=0, st=0, dp_rst=1; a new job then completes correctly.
REQ-038 dout_ready held low 10 cycles in DONE, in_valid pulsed meanwhile -> dout stable, job not accepted; after dout_ready high, IDLE with st=0.

Source files
------------

// File: rtl/xoodyak_sca_pkg.sv
// Shared constants and types for the masked Xoodoo permutation controller.
//   STATE_W  : width of one state share (3 planes x 4 lanes x 32 bits)
//   LANE_W   : lane width, also the round-constant width
//   NR_MAX   : maximum round count
//   RC_TABLE : Xoodoo round constants, element i is RC[i]
//   perm_state_e : controller FSM encoding
package xoodyak_sca_pkg;

  localparam int STATE_W = 384;
  localparam int LANE_W  = 32;
  localparam int NR_MAX  = 12;

  localparam logic [3:0] NR_MAX_4 = 4'd12;

  // Concatenation runs from RC[11] down to RC[0].
  localparam logic [NR_MAX-1:0][LANE_W-1:0] RC_TABLE = {
    32'h0000_0012, 32'h0000_01A0, 32'h0000_00F0, 32'h0000_0380,
    32'h0000_002C, 32'h0000_0060, 32'h0000_0014, 32'h0000_0120,
    32'h0000_00D0, 32'h0000_03C0, 32'h0000_0038, 32'h0000_0058
  };

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } perm_state_e;

endpackage

// File: rtl/xoodoo_rc_rom.sv
// Combinational Xoodoo round-constant lookup.
//   idx : round-constant index 0..11 (12..15 return zero)
//   rc  : 32-bit round constant
module xoodoo_rc_rom
  import xoodyak_sca_pkg::*;
(
  input  logic [3:0]        idx,
  output logic [LANE_W-1:0] rc
);

  always_comb begin
    rc = '0;
    if (idx < NR_MAX_4) rc = RC_TABLE[idx];
  end

endmodule

// File: rtl/xoodoo_perm_ctrl_sca.sv
// Sequencer for an external two-share masked Xoodoo round datapath.
// Each round takes two cycles (PH_A, PH_B); the datapath result is folded
// back into the share registers in the cycle after PH_B.
//   clk, rst                   : clock, async active-low reset
//   in_valid/in_ready          : job handshake, din_0/din_1 shares, nrounds
//   rnd_valid/rnd_ready        : fresh randomness stream rnd_0/rnd_1
//   dp_rst, dp_in_*, dp_rs*,
//   dp_rconst, dp_out_*        : round datapath interface
//   dout_0/dout_1, dout_valid/dout_ready : result handshake
//
// state | meaning
// IDLE  | waiting for a job, datapath held in clear
// PH_A  | datapath captures first register stage; stalls without randomness
// PH_B  | datapath captures nonlinear stage; one randomness word consumed
// FIN   | final datapath output folded into the share registers
// DONE  | result presented until dout_ready
module xoodoo_perm_ctrl_sca
  import xoodyak_sca_pkg::*;
#(
  parameter int NR_DEFAULT = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         nrounds,
  input  logic [STATE_W-1:0] din_0,
  input  logic [STATE_W-1:0] din_1,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic [STATE_W-1:0] rnd_0,
  input  logic [STATE_W-1:0] rnd_1,
  output logic               dp_rst,
  output logic [STATE_W-1:0] dp_in_0,
  output logic [STATE_W-1:0] dp_in_1,
  output logic [STATE_W-1:0] dp_rs0,
  output logic [STATE_W-1:0] dp_rs1,
  output logic [LANE_W-1:0]  dp_rconst,
  input  logic [STATE_W-1:0] dp_out_0,
  input  logic [STATE_W-1:0] dp_out_1,
  output logic [STATE_W-1:0] dout_0,
  output logic [STATE_W-1:0] dout_1,
  output logic               dout_valid,
  input  logic               dout_ready
);

  localparam logic [3:0] NR_DEF_4 = 4'(NR_DEFAULT);

  perm_state_e        state_q;
  logic [3:0]         cnt_q;
  logic [3:0]         nr_q;
  logic               fresh_q;
  logic [STATE_W-1:0] st_0_q;
  logic [STATE_W-1:0] st_1_q;

  logic [3:0]         nr_sel;
  logic [3:0]         cnt_nxt;
  logic [3:0]         rc_idx;
  logic [LANE_W-1:0]  rc_word;

  // Zero picks the default; anything out of 1..12 (including a bad default)
  // is clamped to the maximum.
  always_comb begin
    nr_sel = (nrounds == 4'd0) ? NR_DEF_4 : nrounds;
    if (nr_sel == 4'd0 || nr_sel > NR_MAX_4) nr_sel = NR_MAX_4;
  end

  assign cnt_nxt = cnt_q + 4'd1;
  // Short permutations use the tail of the constant table.
  assign rc_idx  = NR_MAX_4 - nr_q + cnt_q;

  xoodoo_rc_rom u_rc_rom (
    .idx (rc_idx),
    .rc  (rc_word)
  );

  assign dp_rconst = (state_q == PH_A || state_q == PH_B) ? rc_word : '0;
  assign dp_rs0    = rnd_0;
  assign dp_rs1    = rnd_1;

  // The datapath output is only valid in the cycle right after PH_B; that
  // cycle feeds it straight back so the next round needs no extra cycle.
  assign dp_in_0 = fresh_q ? dp_out_0 : st_0_q;
  assign dp_in_1 = fresh_q ? dp_out_1 : st_1_q;

  assign dout_0 = dout_valid ? st_0_q : '0;
  assign dout_1 = dout_valid ? st_1_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      nr_q       <= NR_MAX_4;
      fresh_q    <= 1'b0;
      st_0_q     <= '0;
      st_1_q     <= '0;
      in_ready   <= 1'b1;
      rnd_ready  <= 1'b0;
      dout_valid <= 1'b0;
      dp_rst     <= 1'b1;
    end else begin
      fresh_q <= 1'b0;
      if (fresh_q) begin
        st_0_q <= dp_out_0;
        st_1_q <= dp_out_1;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_0_q   <= din_0;
            st_1_q   <= din_1;
            nr_q     <= nr_sel;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            dp_rst   <= 1'b0;
            state_q  <= PH_A;
          end
        end
        PH_A: begin
          if (rnd_valid) begin
            rnd_ready <= 1'b1;
            state_q   <= PH_B;
          end
        end
        PH_B: begin
          rnd_ready <= 1'b0;
          fresh_q   <= 1'b1;
          if (cnt_nxt < nr_q) begin
            cnt_q   <= cnt_nxt;
            state_q <= PH_A;
          end else begin
            state_q <= FIN;
          end
        end
        FIN: begin
          dout_valid <= 1'b1;
          dp_rst     <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (dout_ready) begin
            // Wipe the shares so nothing survives into the next job.
            st_0_q     <= '0;
            st_1_q     <= '0;
            dout_valid <= 1'b0;
            in_ready   <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready   <= 1'b1;
          rnd_ready  <= 1'b0;
          dout_valid <= 1'b0;
          dp_rst     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xoodoo_perm_ctrl_sca.sv
module tb_xoodoo_perm_ctrl_sca;

  localparam logic [31:0] RC_TAB [12] = '{
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
  };

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   nrounds = 4'd0;
  logic [383:0] din_0 = '0, din_1 = '0;
  logic         rnd_valid = 1'b1;
  logic         rnd_ready;
  logic [383:0] rnd_0, rnd_1;
  logic         dp_rst;
  logic [383:0] dp_in_0, dp_in_1, dp_rs0, dp_rs1;
  logic [31:0]  dp_rconst;
  logic [383:0] dp_out_0 = '0, dp_out_1 = '0;
  logic [383:0] dout_0, dout_1;
  logic         dout_valid;
  logic         dout_ready = 1'b1;

  xoodoo_perm_ctrl_sca #(.NR_DEFAULT(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .nrounds(nrounds), .din_0(din_0), .din_1(din_1),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_0(rnd_0), .rnd_1(rnd_1),
    .dp_rst(dp_rst), .dp_in_0(dp_in_0), .dp_in_1(dp_in_1),
    .dp_rs0(dp_rs0), .dp_rs1(dp_rs1), .dp_rconst(dp_rconst),
    .dp_out_0(dp_out_0), .dp_out_1(dp_out_1),
    .dout_0(dout_0), .dout_1(dout_1), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- Xoodoo reference ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [383:0] lin(input logic [383:0] s, input logic [31:0] rc);
    logic [31:0] a [3][4];
    logic [31:0] p [4];
    logic [31:0] e [4];
    logic [31:0] t [4];
    logic [383:0] r;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = s[(y*4+x)*32 +: 32];
    for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
    for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ e[x];
    for (int x = 0; x < 4; x++) t[x] = a[1][(x+3)%4];
    for (int x = 0; x < 4; x++) begin
      a[1][x] = t[x];
      a[2][x] = rotl(a[2][x], 11);
    end
    a[0][0] = a[0][0] ^ rc;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) r[(y*4+x)*32 +: 32] = a[y][x];
    return r;
  endfunction

  function automatic logic [383:0] nl(input logic [383:0] s);
    logic [31:0] a [3][4];
    logic [31:0] b [3][4];
    logic [383:0] r;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = s[(y*4+x)*32 +: 32];
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) b[y][x] = a[y][x] ^ (~a[(y+1)%3][x] & a[(y+2)%3][x]);
    for (int x = 0; x < 4; x++) begin
      r[(0*4+x)*32 +: 32] = b[0][x];
      r[(1*4+x)*32 +: 32] = rotl(b[1][x], 1);
      r[(2*4+x)*32 +: 32] = rotl(b[2][(x+2)%4], 8);
    end
    return r;
  endfunction

  function automatic logic [383:0] xoodoo_ref(input logic [383:0] s, input int nr);
    logic [383:0] v;
    v = s;
    for (int i = 0; i < nr; i++) v = nl(lin(v, RC_TAB[12-nr+i]));
    return v;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- masked round datapath model ----------------
  logic [383:0] s1_0 = '0, s1_1 = '0;
  always @(posedge clk) begin
    if (dp_rst) begin
      s1_0 <= '0; s1_1 <= '0; dp_out_0 <= '0; dp_out_1 <= '0;
    end else begin
      s1_0     <= lin(dp_in_0, dp_rconst) ^ dp_rs1;
      s1_1     <= lin(dp_in_1, 32'h0) ^ dp_rs1;
      dp_out_0 <= nl(s1_0 ^ s1_1) ^ dp_rs0;
      dp_out_1 <= dp_rs0;
    end
  end

  // randomness source: new word only once the current one is consumed
  initial begin
    rnd_0 = rand384();
    rnd_1 = rand384();
  end
  always @(posedge clk) begin
    if (rnd_valid && rnd_ready) begin
      rnd_0 <= rand384();
      rnd_1 <= rand384();
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [383:0] res;
    int           lat;
    int           pulses;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rc_q[$];
  int          acc_cyc = 0;
  int          pulses = 0;

  initial begin : monitor
    logic         prev_v;
    logic [31:0]  last_rc;
    logic [383:0] held_0, held_1;
    exp_t         e;
    logic [31:0]  erc;
    prev_v = 1'b0;
    last_rc = '0;
    held_0 = '0;
    held_1 = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v = 1'b0;
      end else begin
        if (rnd_ready) begin
          pulses++;
          if (rc_q.size() == 0) check("rc_unexpected", 384'(1), 384'(0));
          else begin
            erc = rc_q.pop_front();
            check("rconst", 384'(last_rc), 384'(erc));
          end
        end else begin
          last_rc = dp_rconst;
        end
        if (dout_valid && !prev_v) begin
          if (exp_q.size() == 0) check("dout_unexpected", 384'(1), 384'(0));
          else begin
            e = exp_q.pop_front();
            check("result", dout_0 ^ dout_1, e.res);
            check("latency", 384'(cyc - acc_cyc), 384'(e.lat));
            check("rnd_pulses", 384'(pulses), 384'(e.pulses));
          end
          held_0 = dout_0;
          held_1 = dout_1;
        end else if (dout_valid) begin
          check("dout_hold_0", dout_0, held_0);
          check("dout_hold_1", dout_1, held_1);
        end
        prev_v = dout_valid;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic expect_job(input logic [383:0] plain, input int nr_eff, input int lat);
    exp_t e;
    e.res = xoodoo_ref(plain, nr_eff);
    e.lat = lat;
    e.pulses = nr_eff;
    exp_q.push_back(e);
    for (int i = 0; i < nr_eff; i++) rc_q.push_back(RC_TAB[12-nr_eff+i]);
  endtask

  // returns #1 after the accepting edge
  task automatic start(input logic [383:0] d0, input logic [383:0] d1, input logic [3:0] nr_in);
    int k;
    @(negedge clk);
    din_0 = d0; din_1 = d1; nrounds = nr_in; in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    check("accept_timeout", 384'(k < 50), 384'(1));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    pulses = 0;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (dout_valid && dout_ready) break;
    end
    check("done_timeout", 384'(k < budget), 384'(1));
    @(negedge clk);
  endtask

  task automatic job(input logic [383:0] plain, input logic [3:0] nr_in, input int nr_eff);
    logic [383:0] m;
    m = rand384();
    expect_job(plain, nr_eff, 2*nr_eff + 1);
    start(plain ^ m, m, nr_in);
    wait_done(100);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 384'(in_ready), 384'(1));
    check({tag, "_dout_valid"}, 384'(dout_valid), 384'(0));
    check({tag, "_dp_rst"}, 384'(dp_rst), 384'(1));
    check({tag, "_rnd_ready"}, 384'(rnd_ready), 384'(0));
    check({tag, "_st_0"}, dp_in_0, 384'(0));
    check({tag, "_st_1"}, dp_in_1, 384'(0));
    check({tag, "_dout_0"}, dout_0, 384'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [383:0] r, x;
    int k;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_rconst", 384'(dp_rconst), 384'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // zero state split into equal shares, full 12 rounds
    r = rand384();
    expect_job('0, 12, 25);
    start(r, r, 4'd12);
    wait_done(100);

    // same job with a 3-cycle randomness stall in round 5 PH_A
    expect_job('0, 12, 28);
    start(r, r, 4'd12);
    repeat (10) @(posedge clk);
    #1 rnd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rnd_valid = 1'b1;
    wait_done(100);

    // 6 rounds, nonzero state; rconst sequence comes from the table tail
    x = rand384();
    job(x, 4'd6, 6);
    // default, clamp and minimum round counts
    job(rand384(), 4'd0, 12);
    job(rand384(), 4'd15, 12);
    job(rand384(), 4'd1, 1);

    // reset during round 7 PH_B
    for (int i = 0; i < 12; i++) rc_q.push_back(RC_TAB[i]);
    start(rand384(), rand384(), 4'd12);
    repeat (15) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    rc_q.delete();
    rst = 1'b1;
    job(rand384(), 4'd12, 12);

    // result held while dout_ready is low; jobs offered meanwhile are ignored
    dout_ready = 1'b0;
    x = rand384();
    expect_job(x, 2, 5);
    start(x ^ r, r, 4'd2);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dout_valid) break;
    end
    check("valid_timeout", 384'(k < 50), 384'(1));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        din_0 = rand384(); din_1 = rand384(); nrounds = 4'd3; in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      @(negedge clk);
      check("hold_in_ready", 384'(in_ready), 384'(0));
    end
    dout_ready = 1'b1;
    @(negedge clk);
    check_idle("release");
    repeat (3) @(negedge clk);
    check("no_accept", 384'(in_ready), 384'(1));

    check("exp_q_empty", 384'(exp_q.size()), 384'(0));
    check("rc_q_empty", 384'(rc_q.size()), 384'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
